// File: rtl/dmbi_reg_responder_pkg.sv
// Shared encodings for the DMBI register responder: frame bit positions, command and
// status codes, reserved register indices and the responder FSM state type.
package dmbi_reg_responder_pkg;

  localparam int unsigned H2fValidBit = 19;
  localparam int unsigned H2fSofBit   = 18;
  localparam int unsigned F2hValidBit = 19;
  localparam int unsigned F2hSofBit   = 18;
  localparam int unsigned F2hBusyBit  = 17;

  localparam logic [1:0] CmdWr = 2'b01;
  localparam logic [1:0] CmdRd = 2'b10;

  localparam logic [1:0] StatOk       = 2'b00;
  localparam logic [1:0] StatBadAddr  = 2'b01;
  localparam logic [1:0] StatReadOnly = 2'b10;
  localparam logic [1:0] StatIllegal  = 2'b11;

  localparam logic [31:0] DeadBeef = 32'hDEAD_BEEF;

  localparam int unsigned RegId   = 0;
  localparam int unsigned RegCtrl = 2;
  localparam int unsigned RegErr  = 3;

  typedef enum logic [2:0] {
    StIdle,
    StGetHi,
    StGetLo,
    StExec,
    StRspHdr,
    StRspHi,
    StRspLo
  } state_e;

  function automatic logic [19:0] f2h_word(input logic valid, input logic sof,
                                           input logic busy, input logic [15:0] payload);
    logic [19:0] w;
    w              = '0;
    w[F2hValidBit] = valid;
    w[F2hSofBit]   = sof;
    w[F2hBusyBit]  = busy;
    w[15:0]        = payload;
    return w;
  endfunction

endpackage

// File: rtl/dmbi_reg_responder_if.sv
// DMBI link word pair: host-to-FPGA request word and FPGA-to-host response word.
interface dmbi_reg_responder_if;
  logic [19:0] dmbi_h2f;
  logic [19:0] dmbi_f2h;

  modport master (output dmbi_h2f, input dmbi_f2h);
  modport slave  (input dmbi_h2f, output dmbi_f2h);
endinterface

// File: rtl/dmbi_reg_responder_regfile.sv
// 32-bit register file: read-only ID and error-counter slots, range check, and a
// saturating error counter bumped by the responder on protocol errors.
module dmbi_reg_responder_regfile
  import dmbi_reg_responder_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'h0D0E_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic        err_inc_i,
  output logic [31:0] rdata_o,
  output logic        addr_ok_o,
  output logic        ro_o,
  output logic [31:0] ctrl_o
);

  logic [31:0] regs_q [NUM_REGS];

  assign addr_ok_o = 32'(addr_i) < NUM_REGS;
  assign ro_o      = (32'(addr_i) == RegId) || (32'(addr_i) == RegErr);

  always_comb begin
    rdata_o = DeadBeef;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(addr_i) == i) rdata_o = regs_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == RegId) ? ID_VALUE : '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (i == RegErr) begin
          // Counter saturates so a stuck link never wraps back to a clean-looking value.
          if (err_inc_i && (regs_q[i] != '1)) regs_q[i] <= regs_q[i] + 32'd1;
        end else if (we_i && !ro_o && (32'(addr_i) == i)) begin
          regs_q[i] <= wdata_i;
        end
      end
    end
  end

  if (NUM_REGS > RegCtrl) begin : g_ctrl
    assign ctrl_o = regs_q[RegCtrl];
  end else begin : g_no_ctrl
    assign ctrl_o = '0;
  end

endmodule

// File: rtl/dmbi_reg_responder.sv
// FPGA-side DMBI responder: frames host requests, drives the register file and
// returns registered response frames.
module dmbi_reg_responder
  import dmbi_reg_responder_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'h0D0E_0001,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  dmbi_reg_responder_if.slave bus,
  output logic [31:0]         ctrl_o,
  output logic [2:0]          led_o
);

  localparam int unsigned TmoW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_e          state_q;
  logic [1:0]      cmd_q;
  logic [7:0]      addr_q;
  logic [15:0]     data_hi_q, data_lo_q;
  logic [31:0]     rdata_q;
  logic [TmoW-1:0] tmo_q;
  logic [19:0]     f2h_q;

  logic        h2f_valid, h2f_sof;
  logic [15:0] h2f_payload;
  logic [1:0]  hdr_cmd;
  logic [7:0]  hdr_addr;
  logic        in_get, in_rsp, tmo_hit, start_hdr, err_inc;
  logic        rf_we, rf_addr_ok, rf_ro;
  logic [31:0] rf_rdata;
  logic [1:0]  status;
  logic        unused_h2f;

  assign h2f_valid   = bus.dmbi_h2f[H2fValidBit];
  assign h2f_sof     = bus.dmbi_h2f[H2fSofBit];
  assign h2f_payload = bus.dmbi_h2f[15:0];
  assign hdr_cmd     = h2f_payload[15:14];
  assign hdr_addr    = h2f_payload[7:0];
  assign unused_h2f  = ^bus.dmbi_h2f[17:16];

  assign in_get    = (state_q == StGetHi) || (state_q == StGetLo);
  assign in_rsp    = (state_q == StExec) || (state_q == StRspHdr) ||
                     (state_q == StRspHi) || (state_q == StRspLo);
  assign tmo_hit   = in_get && !h2f_valid && (tmo_q == TmoW'(TIMEOUT));
  // A header restarts framing from IDLE, and also aborts a partially received write.
  assign start_hdr = h2f_valid && h2f_sof && ((state_q == StIdle) || in_get);

  assign err_inc = (h2f_valid && h2f_sof && in_get) ||
                   (h2f_valid && in_rsp) ||
                   (h2f_valid && !h2f_sof && (state_q == StIdle)) ||
                   tmo_hit;

  assign rf_we = (state_q == StExec) && (cmd_q == CmdWr);

  always_comb begin
    status = StatOk;
    if ((cmd_q != CmdWr) && (cmd_q != CmdRd)) status = StatIllegal;
    else if (!rf_addr_ok)                     status = StatBadAddr;
    else if ((cmd_q == CmdWr) && rf_ro)       status = StatReadOnly;
  end

  dmbi_reg_responder_regfile #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_i    (addr_q),
    .we_i      (rf_we),
    .wdata_i   ({data_hi_q, data_lo_q}),
    .err_inc_i (err_inc),
    .rdata_o   (rf_rdata),
    .addr_ok_o (rf_addr_ok),
    .ro_o      (rf_ro),
    .ctrl_o    (ctrl_o)
  );

  // f2h is loaded together with the next state, so busy always tracks state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      addr_q    <= '0;
      data_hi_q <= '0;
      data_lo_q <= '0;
      rdata_q   <= '0;
      tmo_q     <= '0;
      f2h_q     <= '0;
    end else if (start_hdr) begin
      cmd_q   <= hdr_cmd;
      addr_q  <= hdr_addr;
      tmo_q   <= '0;
      f2h_q   <= f2h_word(1'b0, 1'b0, 1'b1, 16'h0000);
      state_q <= (hdr_cmd == CmdWr) ? StGetHi : StExec;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StGetHi, StGetLo: begin
          if (h2f_valid) begin
            tmo_q <= '0;
            if (state_q == StGetHi) begin
              data_hi_q <= h2f_payload;
              state_q   <= StGetLo;
            end else begin
              data_lo_q <= h2f_payload;
              state_q   <= StExec;
            end
          end else if (tmo_hit) begin
            f2h_q   <= '0;
            state_q <= StIdle;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StExec: begin
          rdata_q <= rf_rdata;
          f2h_q   <= f2h_word(1'b1, 1'b1, 1'b1, {cmd_q, status, 4'h0, addr_q});
          state_q <= StRspHdr;
        end
        StRspHdr: begin
          if (cmd_q == CmdRd) begin
            f2h_q   <= f2h_word(1'b1, 1'b0, 1'b1, rdata_q[31:16]);
            state_q <= StRspHi;
          end else begin
            f2h_q   <= '0;
            state_q <= StIdle;
          end
        end
        StRspHi: begin
          f2h_q   <= f2h_word(1'b1, 1'b0, 1'b1, rdata_q[15:0]);
          state_q <= StRspLo;
        end
        StRspLo: begin
          f2h_q   <= '0;
          state_q <= StIdle;
        end
        default: begin
          f2h_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.dmbi_f2h = f2h_q;
  assign led_o        = ctrl_o[2:0];

endmodule

// File: tb/tb_dmbi_reg_responder.sv
// Directed bench for dmbi_reg_responder: hand-computed response frames per scenario.
module tb_dmbi_reg_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ctrl;
  logic [2:0]  led;
  int          checks = 0;
  int          errors = 0;

  dmbi_reg_responder_if bus();

  dmbi_reg_responder #(
    .NUM_REGS (16),
    .ID_VALUE (32'h0D0E_0001),
    .TIMEOUT  (255)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .ctrl_o (ctrl),
    .led_o  (led)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one word for exactly one sampling edge; returns 1 time unit after that edge.
  task automatic drive(input logic [19:0] w);
    @(negedge clk);
    bus.dmbi_h2f = w;
    @(posedge clk);
    #1;
    bus.dmbi_h2f = '0;
  endtask

  task automatic rd(input logic [7:0] addr, output logic [19:0] hdr,
                    output logic [19:0] hi, output logic [19:0] lo);
    drive(20'hC8000 | {12'h000, addr});
    step();
    hdr = bus.dmbi_f2h;
    step();
    hi = bus.dmbi_f2h;
    step();
    lo = bus.dmbi_f2h;
    step();
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data, output logic [19:0] hdr);
    drive(20'hC4000 | {12'h000, addr});
    drive({4'h8, data[31:16]});
    drive({4'h8, data[15:0]});
    step();
    hdr = bus.dmbi_f2h;
    step();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.dmbi_h2f = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.dmbi_f2h !== 20'h0) begin errors++;
      $display("FAIL reset_f2h got %h want 00000", bus.dmbi_f2h); end
    checks++; if (ctrl !== 32'h0) begin errors++;
      $display("FAIL reset_ctrl got %h want 00000000", ctrl); end
    checks++; if (led !== 3'b000) begin errors++;
      $display("FAIL reset_led got %b want 000", led); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_id();
    drive(20'hC8000);
    checks++; if (bus.dmbi_f2h !== 20'h20000) begin errors++;
      $display("FAIL rd_id_exec got %h want 20000", bus.dmbi_f2h); end
    step();
    checks++; if (bus.dmbi_f2h !== 20'hE8000) begin errors++;
      $display("FAIL rd_id_hdr got %h want E8000", bus.dmbi_f2h); end
    step();
    checks++; if (bus.dmbi_f2h !== 20'hA0D0E) begin errors++;
      $display("FAIL rd_id_hi got %h want A0D0E", bus.dmbi_f2h); end
    step();
    checks++; if (bus.dmbi_f2h !== 20'hA0001) begin errors++;
      $display("FAIL rd_id_lo got %h want A0001", bus.dmbi_f2h); end
    step();
    checks++; if (bus.dmbi_f2h !== 20'h00000) begin errors++;
      $display("FAIL rd_id_idle got %h want 00000", bus.dmbi_f2h); end
  endtask

  task automatic test_write_ctrl();
    logic [19:0] hdr, hi, lo;
    drive(20'hC4002);
    drive(20'h80000);
    drive(20'h80005);
    checks++; if (ctrl !== 32'h0) begin errors++;
      $display("FAIL wr_ctrl_early got %h want 00000000", ctrl); end
    step();
    checks++; if (bus.dmbi_f2h !== 20'hE4002) begin errors++;
      $display("FAIL wr_ctrl_hdr got %h want E4002", bus.dmbi_f2h); end
    checks++; if (ctrl !== 32'h5) begin errors++;
      $display("FAIL wr_ctrl_value got %h want 00000005", ctrl); end
    checks++; if (led !== 3'b101) begin errors++;
      $display("FAIL wr_ctrl_led got %b want 101", led); end
    step();
    checks++; if (bus.dmbi_f2h !== 20'h00000) begin errors++;
      $display("FAIL wr_ctrl_idle got %h want 00000", bus.dmbi_f2h); end
    rd(8'h02, hdr, hi, lo);
    checks++; if ({hdr, hi, lo} !== {20'hE8002, 20'hA0000, 20'hA0005}) begin errors++;
      $display("FAIL rd_ctrl got %h %h %h want E8002 A0000 A0005", hdr, hi, lo); end
  endtask

  task automatic test_ro_badaddr();
    logic [19:0] hdr, hi, lo;
    wr(8'h00, 32'h1234_5678, hdr);
    checks++; if (hdr !== 20'hE6000) begin errors++;
      $display("FAIL wr_id_status got %h want E6000", hdr); end
    wr(8'h03, 32'h0000_0077, hdr);
    checks++; if (hdr !== 20'hE6003) begin errors++;
      $display("FAIL wr_err_status got %h want E6003", hdr); end
    wr(8'h20, 32'h0000_0001, hdr);
    checks++; if (hdr !== 20'hE5020) begin errors++;
      $display("FAIL wr_bad_status got %h want E5020", hdr); end
    rd(8'h20, hdr, hi, lo);
    checks++; if ({hdr, hi, lo} !== {20'hE9020, 20'hADEAD, 20'hABEEF}) begin errors++;
      $display("FAIL rd_bad got %h %h %h want E9020 ADEAD ABEEF", hdr, hi, lo); end
    rd(8'h00, hdr, hi, lo);
    checks++; if ({hdr, hi, lo} !== {20'hE8000, 20'hA0D0E, 20'hA0001}) begin errors++;
      $display("FAIL rd_id_unchanged got %h %h %h want E8000 A0D0E A0001", hdr, hi, lo); end
    rd(8'h03, hdr, hi, lo);
    checks++; if ({hi, lo} !== {20'hA0000, 20'hA0000}) begin errors++;
      $display("FAIL rd_err_zero got %h %h want A0000 A0000", hi, lo); end
  endtask

  task automatic test_illegal();
    drive(20'hCC005);
    step();
    checks++; if (bus.dmbi_f2h !== 20'hEF005) begin errors++;
      $display("FAIL illegal_hdr got %h want EF005", bus.dmbi_f2h); end
    step();
    checks++; if (bus.dmbi_f2h !== 20'h00000) begin errors++;
      $display("FAIL illegal_no_data got %h want 00000", bus.dmbi_f2h); end
  endtask

  task automatic test_abort();
    logic [19:0] hdr, hi, lo;
    drive(20'hC4001);
    drive(20'h81234);
    rd(8'h01, hdr, hi, lo);
    checks++; if ({hdr, hi, lo} !== {20'hE8001, 20'hA0000, 20'hA0000}) begin errors++;
      $display("FAIL abort_rd got %h %h %h want E8001 A0000 A0000", hdr, hi, lo); end
    rd(8'h03, hdr, hi, lo);
    checks++; if ({hi, lo} !== {20'hA0000, 20'hA0001}) begin errors++;
      $display("FAIL abort_errcnt got %h %h want A0000 A0001", hi, lo); end
  endtask

  task automatic test_timeout();
    logic [19:0] hdr, hi, lo;
    logic        seen_valid;
    seen_valid = 1'b0;
    drive(20'hC4001);
    for (int i = 0; i < 255; i++) begin
      step();
      if (bus.dmbi_f2h[19]) seen_valid = 1'b1;
    end
    checks++; if (bus.dmbi_f2h !== 20'h20000) begin errors++;
      $display("FAIL tmo_still_busy got %h want 20000", bus.dmbi_f2h); end
    step();
    checks++; if (bus.dmbi_f2h !== 20'h00000) begin errors++;
      $display("FAIL tmo_idle got %h want 00000", bus.dmbi_f2h); end
    checks++; if (seen_valid !== 1'b0) begin errors++;
      $display("FAIL tmo_no_rsp got %b want 0", seen_valid); end
    rd(8'h03, hdr, hi, lo);
    checks++; if ({hi, lo} !== {20'hA0000, 20'hA0002}) begin errors++;
      $display("FAIL tmo_errcnt got %h %h want A0000 A0002", hi, lo); end
    // Stray data word in IDLE, then a word arriving while EXEC is in progress.
    drive(20'h80055);
    checks++; if (bus.dmbi_f2h !== 20'h00000) begin errors++;
      $display("FAIL stray_idle got %h want 00000", bus.dmbi_f2h); end
    drive(20'hC8001);
    drive(20'h80077);
    checks++; if (bus.dmbi_f2h !== 20'hE8001) begin errors++;
      $display("FAIL drop_in_exec got %h want E8001", bus.dmbi_f2h); end
    repeat (3) step();
    rd(8'h03, hdr, hi, lo);
    checks++; if ({hi, lo} !== {20'hA0000, 20'hA0004}) begin errors++;
      $display("FAIL drop_errcnt got %h %h want A0000 A0004", hi, lo); end
  endtask

  task automatic test_reset_mid();
    logic [19:0] hdr, hi, lo;
    drive(20'hC8000);
    step();
    step();
    checks++; if (bus.dmbi_f2h !== 20'hA0D0E || ctrl !== 32'h5) begin errors++;
      $display("FAIL pre_reset got %h %h want A0D0E 00000005", bus.dmbi_f2h, ctrl); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.dmbi_f2h !== 20'h00000) begin errors++;
      $display("FAIL mid_reset_f2h got %h want 00000", bus.dmbi_f2h); end
    checks++; if (ctrl !== 32'h0 || led !== 3'b000) begin errors++;
      $display("FAIL mid_reset_ctrl got %h %b want 00000000 000", ctrl, led); end
    @(negedge clk);
    rst_n = 1'b1;
    rd(8'h00, hdr, hi, lo);
    checks++; if ({hdr, hi, lo} !== {20'hE8000, 20'hA0D0E, 20'hA0001}) begin errors++;
      $display("FAIL post_reset_rd got %h %h %h want E8000 A0D0E A0001", hdr, hi, lo); end
    rd(8'h03, hdr, hi, lo);
    checks++; if ({hi, lo} !== {20'hA0000, 20'hA0000}) begin errors++;
      $display("FAIL post_reset_errcnt got %h %h want A0000 A0000", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_write_ctrl();
    test_ro_badaddr();
    test_illegal();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
